// File: rtl/spi_bank_loader_pkg.sv
// Shared encodings for the SPI bank loader.
// FSM states and SPI frame header length.
package spi_bank_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_HI = 2'd1,
    ADDR_LO = 2'd2,
    DATA    = 2'd3
  } state_e;

  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/spi_rx_byte.sv
// SPI mode-0 slave receiver: synchronises the pins, detects edges
// and deserialises MSB-first bytes into a one-cycle byte strobe.
module spi_rx_byte
  import spi_bank_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_cs_fall,
  output logic       o_cs_rise,
  output logic       o_cs_high
);

  logic       r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic       r_cs_s1, r_cs_s2, r_cs_prev;
  logic       r_mosi_s1, r_mosi_s2;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_byte;
  logic       r_byte_valid;
  logic       w_sclk_rise;

  assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_prev;
  assign o_cs_fall    = ~r_cs_s2 & r_cs_prev;
  assign o_cs_rise    = r_cs_s2 & ~r_cs_prev;
  assign o_cs_high    = r_cs_s2 & r_cs_prev;
  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_cs_s1     <= 1'b1;
      r_cs_s2     <= 1'b1;
      r_cs_prev   <= 1'b1;
      r_mosi_s1   <= 1'b0;
      r_mosi_s2   <= 1'b0;
    end else begin
      r_sclk_s1   <= i_sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_cs_s1     <= i_cs_n;
      r_cs_s2     <= r_cs_s1;
      r_cs_prev   <= r_cs_s2;
      r_mosi_s1   <= i_mosi;
      r_mosi_s2   <= r_mosi_s1;
    end
  end

  // A deselected link always restarts at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (r_cs_s2) begin
        r_bit_cnt <= 3'd0;
      end else if (w_sclk_rise) begin
        r_shift   <= {r_shift[6:0], r_mosi_s2};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte       <= {r_shift[6:0], r_mosi_s2};
          r_byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_bank_loader.sv
// Loads a bank memory from an SPI frame: 2-byte start address then data,
// with busy/done handshake to the accelerator and a sticky overflow flag.
module spi_bank_loader
  import spi_bank_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  wrenb,
  output logic                  csen,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   byte_cnt,
  output logic                  ovf_err,
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DATA_DEPTH);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_cs_high;
  logic       w_in_range;
  logic       w_wr_now;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic [DATA_WIDTH-1:0] r_data_b;
  logic                  r_wrenb;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_done_pend;
  logic [ADDR_WIDTH:0]   r_byte_cnt;
  logic                  r_ovf;
  logic                  r_armed;
  logic [1:0]            r_settle;

  spi_rx_byte u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_sclk       (spi_sclk),
    .i_cs_n       (spi_cs_n),
    .i_mosi       (spi_mosi),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_cs_fall    (w_cs_fall),
    .o_cs_rise    (w_cs_rise),
    .o_cs_high    (w_cs_high)
  );

  assign w_in_range = ({1'b0, r_addr} < LP_DEPTH);
  assign w_wr_now   = (r_state == DATA) && w_byte_valid && w_in_range;

  assign addr_b    = r_addr_b;
  assign data_b    = r_data_b;
  assign wrenb     = r_wrenb;
  assign csen      = r_busy;
  assign load_busy = r_busy;
  assign load_done = r_done;
  assign byte_cnt  = r_byte_cnt;
  assign ovf_err   = r_ovf;

  // r_armed blocks a frame already running when reset released;
  // r_settle lets the cs_n synchroniser flush its reset value first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_addr_b    <= '0;
      r_data_b    <= '0;
      r_wrenb     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_pend <= 1'b0;
      r_byte_cnt  <= '0;
      r_ovf       <= 1'b0;
      r_armed     <= 1'b0;
      r_settle    <= 2'd0;
    end else begin
      r_wrenb     <= 1'b0;
      r_done      <= r_done_pend;
      r_done_pend <= 1'b0;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      if (w_cs_high && r_settle == 2'd3) r_armed <= 1'b1;
      if (err_clr) r_ovf <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_cs_fall && r_armed) begin
            r_state    <= ADDR_HI;
            r_busy     <= 1'b1;
            r_byte_cnt <= '0;
          end
        end
        ADDR_HI: begin
          if (w_byte_valid) begin
            r_addr[ADDR_WIDTH-1:8] <= w_byte[ADDR_WIDTH-9:0];
            r_state                <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (w_byte_valid) begin
            r_addr[7:0] <= w_byte;
            r_state     <= DATA;
          end
        end
        DATA: begin
          if (w_byte_valid) begin
            if (w_in_range) begin
              r_wrenb    <= 1'b1;
              r_addr_b   <= r_addr;
              r_data_b   <= w_byte;
              r_byte_cnt <= r_byte_cnt + (ADDR_WIDTH+1)'(1);
            end else begin
              r_ovf <= 1'b1;
            end
            if (r_addr != '1) r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase

      // A byte landing with cs_n rise still writes; done then waits a cycle.
      if (w_cs_rise && r_state != IDLE) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        if (w_wr_now)
          r_done_pend <= 1'b1;
        else if (r_byte_cnt != '0)
          r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_bank_loader.sv
// Randomised SPI frame bench for spi_bank_loader with a frame-level
// reference model of the bank writes, byte count and overflow flag.
module tb_spi_bank_loader;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int AMAX  = (1 << AW) - 1;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          spi_sclk = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          err_clr  = 1'b0;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_b;
  logic          wrenb;
  logic          csen;
  logic          load_busy;
  logic          load_done;
  logic [AW:0]   byte_cnt;
  logic          ovf_err;

  spi_bank_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .addr_b    (addr_b),
    .data_b    (data_b),
    .wrenb     (wrenb),
    .csen      (csen),
    .load_busy (load_busy),
    .load_done (load_done),
    .byte_cnt  (byte_cnt),
    .ovf_err   (ovf_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // bus monitor
  int          cyc = 0;
  int          n_done = 0;
  int          n_gap = 0;
  int          n_csen = 0;
  int          n_done_busy = 0;
  int          n_busy = 0;
  int          done_cyc = 0;
  int          last_wr_cyc = 0;
  logic        prev_wr = 1'b0;
  logic [31:0] wr_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_busy !== csen) n_csen++;
    if (load_busy) n_busy++;
    if (wrenb) begin
      if (prev_wr) n_gap++;
      wr_log.push_back({11'd0, addr_b, data_b});
      last_wr_cyc = cyc;
    end
    prev_wr = wrenb;
    if (load_done) begin
      n_done++;
      done_cyc = cyc;
      if (load_busy) n_done_busy++;
    end
  end

  // reference model: frame bytes -> expected bank writes
  logic [7:0]  tx_q[$];
  logic [31:0] exp_w[$];
  bit          m_ovf = 1'b0;
  bit          m_last_wr;

  task automatic model_frame();
    int a;
    exp_w.delete();
    m_last_wr = 1'b0;
    if (tx_q.size() >= 2) begin
      a = (int'(tx_q[0]) % 32) * 256 + int'(tx_q[1]);
      for (int i = 2; i < tx_q.size(); i++) begin
        m_last_wr = (a < DEPTH);
        if (a < DEPTH) exp_w.push_back(32'(a * 256 + int'(tx_q[i])));
        else m_ovf = 1'b1;
        if (a < AMAX) a++;
      end
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb, input bit co);
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = b[i];
      half();
      spi_sclk = 1'b1;
      if (co && i == 8 - nb) begin
        @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
      end else begin
        half();
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int part, input bit co);
    int bw;
    int bd;
    int nw;
    bit co_last;
    bw = wr_log.size();
    bd = n_done;
    co_last = co && part == 0 && tx_q.size() > 0;
    model_frame();
    @(negedge clk);
    spi_cs_n = 1'b0;
    half();
    for (int k = 0; k < tx_q.size(); k++) begin
      send_bits(tx_q[k], 8, co_last && k == tx_q.size() - 1);
      if (k == 0) begin
        check("busy_hdr", 32'(load_busy), 1);
        check("cnt_clr", 32'(byte_cnt), 0);
      end
    end
    if (part > 0) send_bits(8'($urandom), part, 1'b0);
    if (!co_last) begin
      half();
      spi_cs_n = 1'b1;
    end
    repeat (8) @(negedge clk);
    nw = wr_log.size() - bw;
    check("n_wr", nw, exp_w.size());
    for (int i = 0; i < nw && i < exp_w.size(); i++)
      check("wr", wr_log[bw + i], exp_w[i]);
    check("byte_cnt", 32'(byte_cnt), exp_w.size());
    check("done", n_done - bd, (exp_w.size() != 0) ? 1 : 0);
    check("ovf", 32'(ovf_err), 32'(m_ovf));
    check("busy_end", 32'(load_busy), 0);
    if (exp_w.size() != 0 && n_done != bd) begin
      if (co_last && m_last_wr)
        check("done_lat", done_cyc - last_wr_cyc, 1);
      else
        check("done_after_wr", 32'(done_cyc > last_wr_cyc), 1);
    end
  endtask

  initial begin
    int bw;
    int bd;
    int bb;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr_b), 0);
    check("rst_misc",
          32'({data_b, wrenb, csen, load_busy, load_done, byte_cnt, ovf_err}), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_busy", 32'(load_busy), 0);

    // basic two-byte load
    tx_q = {8'h00, 8'h10, 8'hA5, 8'h3C};
    run_frame(0, 1'b0);

    // crosses the end of the bank, then clear the flag
    tx_q = {8'h03, 8'hFE, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(0, 1'b0);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf = 1'b0;
    check("err_clr", 32'(ovf_err), 0);

    // header plus a partial byte
    tx_q = {8'h00, 8'h00};
    run_frame(5, 1'b0);

    // reset in the middle of a frame, cs_n still low after release
    @(negedge clk);
    spi_cs_n = 1'b0;
    half();
    send_bits(8'h00, 8, 1'b0);
    send_bits(8'h03, 4, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_addr", 32'(addr_b), 0);
    check("mid_rst_misc",
          32'({data_b, wrenb, csen, load_busy, load_done, byte_cnt, ovf_err}), 0);
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bw = wr_log.size();
    bd = n_done;
    bb = n_busy;
    send_bits(8'h00, 8, 1'b0);
    send_bits(8'h00, 8, 1'b0);
    send_bits(8'h55, 8, 1'b0);
    send_bits(8'h66, 8, 1'b0);
    half();
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("stale_wr", wr_log.size() - bw, 0);
    check("stale_done", n_done - bd, 0);
    check("stale_busy", n_busy - bb, 0);
    tx_q = {8'h00, 8'h05, 8'hFF};
    run_frame(0, 1'b0);

    // last byte lands with the cs_n rise
    tx_q = {8'h01, 8'h20, 8'h5A, 8'hC3};
    run_frame(0, 1'b1);

    // back-to-back frames, about one sclk period apart
    tx_q = {8'h00, 8'h40, 8'h11, 8'h22, 8'h33};
    run_frame(0, 1'b0);
    tx_q = {8'h00, 8'h80, 8'h44};
    run_frame(0, 1'b0);

    repeat (14) begin : rnd
      int  n;
      int  part;
      bit  co;
      bit  near;
      near = 1'($urandom_range(1));
      tx_q.delete();
      if (near) begin
        tx_q.push_back((8'($urandom) & 8'hE0) | 8'h03);
        tx_q.push_back(8'($urandom_range(255, 248)));
      end else begin
        tx_q.push_back(8'($urandom));
        tx_q.push_back(8'($urandom));
      end
      n = $urandom_range(4);
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      if ($urandom_range(7) == 0) begin
        while (tx_q.size() > 1) void'(tx_q.pop_back());
      end
      co = (tx_q.size() > 2) && ($urandom_range(1) == 1);
      part = co ? 0 : $urandom_range(7);
      run_frame(part, co);
      if ($urandom_range(2) == 0) begin
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ovf = 1'b0;
        check("err_clr_r", 32'(ovf_err), 0);
      end
    end

    check("wr_gap", n_gap, 0);
    check("csen_eq_busy", n_csen, 0);
    check("done_idle", n_done_busy, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
